// File: rtl/disp_pkg.sv
// ============================================================================
// Module      : disp_pkg
// Description : Shared widths, blank code and arbiter state type for the
//               display arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package disp_pkg;

  localparam int DIGIT_W = 5;
  localparam int NDIG    = 4;
  localparam int DISP_W  = DIGIT_W * NDIG;

  localparam logic [DIGIT_W-1:0] DEF_BLANK_CODE = 5'd31;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/disp_arbiter_rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker: first set request found
//               starting at ptr and wrapping, returned one-hot with valid.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter int NREQ  = 3,
  parameter int PTR_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic             valid
);

  always_comb begin
    int w_idx;
    grant = '0;
    valid = 1'b0;
    w_idx = 0;
    for (int off = 0; off < NREQ; off++) begin
      w_idx = int'(ptr) + off;
      if (w_idx >= NREQ) begin
        w_idx = w_idx - NREQ;
      end
      if (!valid && req[w_idx]) begin
        grant[w_idx] = 1'b1;
        valid        = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/disp_arbiter.sv
// ============================================================================
// Module      : disp_arbiter
// Description : Round-robin, minimum-hold arbiter sharing the 4-digit display
//               between NREQ requesters. Optional macro ARB_PRIO_EN makes
//               requester 0 urgent (preempts and is never rotated out).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module disp_arbiter
  import disp_pkg::*;
#(
  parameter int                 NREQ        = 3,
  parameter int                 HOLD_CYCLES = 50000000,
  parameter logic [DIGIT_W-1:0] BLANK_CODE  = DEF_BLANK_CODE
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req,
  input  logic [DISP_W*NREQ-1:0] disps_in,
  output logic [NREQ-1:0]        grant,
  output logic [DISP_W-1:0]      disps,
  output logic                   busy
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = $clog2(HOLD_CYCLES);

  localparam logic [0:0]       ST_IDLE  = IDLE;
  localparam logic [0:0]       ST_HOLD  = HOLD;
  localparam logic [CNT_W-1:0] c_RELOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [NREQ-1:0]  c_REQ0   = {{(NREQ-1){1'b0}}, 1'b1};

  logic [0:0]        r_state, w_nxt_state;
  logic [CNT_W-1:0]  r_cnt, w_nxt_cnt;
  logic [PTR_W-1:0]  r_ptr, w_nxt_ptr;
  logic [NREQ-1:0]   w_pick_req, w_pick_grant, w_sel_grant, w_nxt_grant;
  logic              w_pick_valid, w_owner_req, w_take, w_urgent, w_keep;
  logic [DISP_W-1:0] w_nxt_disps;

  // The current owner is excluded so a rotation never re-picks it.
  assign w_pick_req  = req & ~grant;
  assign w_owner_req = |(req & grant);

`ifdef ARB_PRIO_EN
  assign w_urgent = req[0] & ~grant[0];
  assign w_keep   = req[0] & grant[0];
`else
  assign w_urgent = 1'b0;
  assign w_keep   = 1'b0;
`endif

  assign w_sel_grant = w_urgent ? c_REQ0 : w_pick_grant;

  rr_pick #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req   (w_pick_req),
    .ptr   (r_ptr),
    .grant (w_pick_grant),
    .valid (w_pick_valid)
  );

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_grant = grant;
    w_nxt_cnt   = r_cnt;
    w_nxt_ptr   = r_ptr;
    w_take      = 1'b0;
    case (r_state)
      ST_IDLE: w_take = w_pick_valid;
      ST_HOLD: begin
        if (w_urgent) begin
          w_take = 1'b1;
        end else if (!w_owner_req) begin
          if (w_pick_valid) begin
            w_take = 1'b1;
          end else begin
            w_nxt_state = ST_IDLE;
            w_nxt_grant = '0;
            w_nxt_cnt   = '0;
          end
        end else if (r_cnt == '0) begin
          if (w_pick_valid && !w_keep) begin
            w_take = 1'b1;
          end else begin
            w_nxt_cnt = c_RELOAD;
          end
        end else begin
          w_nxt_cnt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_nxt_state = ST_IDLE;
        w_nxt_grant = '0;
        w_nxt_cnt   = '0;
      end
    endcase

    if (w_take) begin
      w_nxt_state = ST_HOLD;
      w_nxt_grant = w_sel_grant;
      w_nxt_cnt   = c_RELOAD;
      for (int i = 0; i < NREQ; i++) begin
        if (w_sel_grant[i]) begin
          w_nxt_ptr = (i == NREQ - 1) ? '0 : PTR_W'(i + 1);
        end
      end
    end
  end

  // Word follows the next grant so digits and owner change on one edge.
  always_comb begin
    w_nxt_disps = {NDIG{BLANK_CODE}};
    for (int i = 0; i < NREQ; i++) begin
      if (w_nxt_grant[i]) begin
        w_nxt_disps = disps_in[DISP_W*i +: DISP_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_ptr   <= '0;
      grant   <= '0;
      busy    <= 1'b0;
      disps   <= {NDIG{BLANK_CODE}};
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
      r_ptr   <= w_nxt_ptr;
      grant   <= w_nxt_grant;
      busy    <= |w_nxt_grant;
      disps   <= w_nxt_disps;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_disp_arbiter.sv
// ============================================================================
// Module      : tb_disp_arbiter
// Description : Directed self-checking bench for disp_arbiter
//               (NREQ=3, HOLD_CYCLES=4, BLANK_CODE=31).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_disp_arbiter;

`ifdef ARB_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  localparam logic [19:0] BLANK = 20'hFFFFF;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req;
  logic [59:0] disps_in;
  logic [2:0]  grant;
  logic [19:0] disps;
  logic        busy;

  int n_checks;
  int n_errors;

  logic [19:0] w [3];
  logic [2:0]  order [4];

  disp_arbiter #(
    .NREQ        (3),
    .HOLD_CYCLES (4),
    .BLANK_CODE  (5'd31)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .disps_in (disps_in),
    .grant    (grant),
    .disps    (disps),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_words();
    disps_in = {w[2], w[1], w[0]};
  endtask

  function automatic logic [19:0] word_of(input logic [2:0] g);
    logic [19:0] r;
    r = BLANK;
    if (g[0]) r = w[0];
    if (g[1]) r = w[1];
    if (g[2]) r = w[2];
    return r;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    w[0] = 20'h11111;
    w[1] = 20'h01234;
    w[2] = 20'h0ABCD;
    set_words();
    req   = 3'b000;
    rst_n = 1'b0;
    #12;
    chk("rst_grant", grant, 3'b000);
    chk("rst_busy",  busy,  1'b0);
    chk("rst_disps", disps, BLANK);
    rst_n = 1'b1;
    tick();
    tick();
    chk("idle_disps", disps, BLANK);

    // Single requester takes and keeps the display.
    req = 3'b010;
    tick();
    chk("t2_grant", grant, 3'b010);
    chk("t2_busy",  busy,  1'b1);
    chk("t2_disps", disps, 20'h01234);
    for (int i = 0; i < 5; i++) tick();
    chk("t2_hold_grant", grant, 3'b010);

    // Owner word change appears one edge later.
    w[1] = 20'h05678;
    set_words();
    chk("t5_before", disps, 20'h01234);
    tick();
    chk("t5_disps", disps, 20'h05678);
    chk("t5_grant", grant, 3'b010);

    // Owner drops with nobody waiting -> idle.
    req = 3'b000;
    tick();
    chk("t4_idle_grant", grant, 3'b000);
    chk("t4_idle_busy",  busy,  1'b0);
    chk("t4_idle_disps", disps, BLANK);

    // Asynchronous reset mid-hold.
    req = 3'b010;
    tick();
    tick();
    chk("pre_rst_grant", grant, 3'b010);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_grant", grant, 3'b000);
    chk("async_busy",  busy,  1'b0);
    chk("async_disps", disps, BLANK);
    req = 3'b000;
    tick();
    rst_n = 1'b1;
    tick();

    // Full rotation from pointer 0, each owner held 4 cycles.
    w[1] = 20'h01234;
    set_words();
    if (PRIO) begin
      order[0] = 3'b001; order[1] = 3'b001; order[2] = 3'b001; order[3] = 3'b001;
    end else begin
      order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100; order[3] = 3'b001;
    end
    req = 3'b111;
    for (int k = 0; k < 16; k++) begin
      tick();
      chk($sformatf("t3_grant_%0d", k), grant, order[k/4]);
      chk($sformatf("t3_disps_%0d", k), disps, word_of(order[k/4]));
    end

    // Owner 010 drops at cnt=2 while req[2] waits.
    tick();
    chk("t4_g17", grant, PRIO ? 3'b001 : 3'b010);
    tick();
    chk("t4_g18", grant, PRIO ? 3'b001 : 3'b010);
    req = 3'b100;
    tick();
    chk("t4_release_grant", grant, 3'b100);
    chk("t4_release_disps", disps, 20'h0ABCD);

    // req[0] rises while 100 owns with cnt=3.
    req = 3'b101;
    tick();
    chk("t6_e1", grant, PRIO ? 3'b001 : 3'b100);
    tick();
    chk("t6_e2", grant, PRIO ? 3'b001 : 3'b100);
    tick();
    chk("t6_e3", grant, PRIO ? 3'b001 : 3'b100);
    tick();
    chk("t6_e4_grant", grant, 3'b001);
    chk("t6_e4_disps", disps, 20'h11111);

    req = 3'b000;
    tick();
    chk("end_grant", grant, 3'b000);
    chk("end_busy",  busy,  1'b0);
    chk("end_disps", disps, BLANK);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
